// File: rtl/rv_iter_divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One operation in flight; valid/ready on both sides, flush drops everything.
module rv_iter_divider #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result
);
    // state | meaning
    // IDLE  | waiting for a request, in_ready high
    // CALC  | one restoring iteration per edge, N edges
    // DONE  | result held until out_ready
    localparam int CW = $clog2(N) + 1;
    localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state, state_nxt;
    logic           rem_sel;
    logic           neg_q, neg_r;
    logic [N-1:0]   rem_r;
    logic [N-1:0]   quo_r;
    logic [N-1:0]   dvs_r;
    logic [CW-1:0]  cnt;

    logic           accept;
    logic           is_signed;
    logic [N-1:0]   abs_a, abs_b;
    logic           div_zero, ovf, special;
    logic [N-1:0]   spec_res;
    logic [N:0]     shifted, trial;
    logic [N-1:0]   rem_nxt, quo_nxt;
    logic           last_iter;
    logic [N-1:0]   quo_fix, rem_fix, fin_res;

    assign in_ready  = (state == IDLE) && rst_n;
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready && !flush;

    assign is_signed = ~op[0];
    assign abs_a     = (is_signed && a[N-1]) ? -a : a;
    assign abs_b     = (is_signed && b[N-1]) ? -b : b;
    assign div_zero  = (b == '0);
    assign ovf       = is_signed && (a == MIN_NEG) && (b == '1);
    assign special   = div_zero || ovf;
    // Divide-by-zero returns the raw dividend as remainder, not its magnitude
    assign spec_res  = div_zero ? (op[1] ? a : '1) : (op[1] ? '0 : MIN_NEG);

    // R stays below the divisor, so its top bit never needs storing
    assign shifted   = {rem_r, quo_r[N-1]};
    assign trial     = shifted - {1'b0, dvs_r};
    assign rem_nxt   = trial[N] ? shifted[N-1:0] : trial[N-1:0];
    assign quo_nxt   = {quo_r[N-2:0], ~trial[N]};
    assign last_iter = (cnt == CW'(N - 1));

    assign quo_fix   = neg_q ? -quo_nxt : quo_nxt;
    assign rem_fix   = neg_r ? -rem_nxt : rem_nxt;
    assign fin_res   = rem_sel ? rem_fix : quo_fix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept)    state_nxt = special ? DONE : CALC;
            CALC: if (last_iter) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_sel <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            rem_r   <= '0;
            quo_r   <= '0;
            dvs_r   <= '0;
            cnt     <= '0;
            result  <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rem_sel <= op[1];
                        neg_q   <= is_signed && (a[N-1] ^ b[N-1]);
                        neg_r   <= is_signed && a[N-1];
                        dvs_r   <= abs_b;
                        quo_r   <= abs_a;
                        rem_r   <= '0;
                        cnt     <= '0;
                        if (special) result <= spec_res;
                    end
                end
                CALC: begin
                    rem_r <= rem_nxt;
                    quo_r <= quo_nxt;
                    cnt   <= cnt + 1'b1;
                    if (last_iter) result <= fin_res;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rv_iter_divider.sv
// Directed bench for rv_iter_divider: arithmetic, special cases, latency,
// backpressure, flush and reset abort, all with hand-computed expectations.
module tb_rv_iter_divider;
    localparam int N = 32;
    localparam logic [1:0] DIV = 2'd0, DIVU = 2'd1, REM = 2'd2, REMU = 2'd3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   op = '0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] result;

    int errors = 0;
    int checks = 0;

    rv_iter_divider #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Edge count includes the accept edge: special cases finish on it (1),
    // normal operations need N more iteration edges (N+1).
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [N-1:0] av, input logic [N-1:0] bv,
                          input logic [N-1:0] exp_res, input int exp_edges,
                          input bit take);
        int n;
        int w;
        w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk); #1; w++;
        end
        chk({tag, "_ready"}, in_ready, 1);
        op = o; a = av; b = bv; in_valid = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
            if (n == 1) begin
                in_valid = 1'b0;
                a = '1; b = 32'd1; op = ~o;
            end
        end while (!out_valid && n < 100);
        chk({tag, "_lat"}, N'(n), N'(exp_edges));
        chk({tag, "_res"}, result, exp_res);
        if (take) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            chk({tag, "_ovdrop"}, out_valid, 0);
        end
    endtask

    initial begin
        bit seen;

        #2 rst_n = 1'b0;
        #2;
        chk("rst_ov", out_valid, 0);
        chk("rst_res", result, 0);
        chk("rst_inr", in_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_inr", in_ready, 1);

        run_op("divu_100_7", DIVU, 100, 7, 14, 33, 1);
        run_op("remu_100_7", REMU, 100, 7, 2, 33, 1);
        run_op("div_m7_2",   DIV, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, 33, 1);
        run_op("rem_m7_2",   REM, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, 33, 1);
        run_op("rem_7_m2",   REM, 7, 32'hFFFF_FFFE, 1, 33, 1);
        run_op("div_7_m2",   DIV, 7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 1);
        run_op("rem_m100_7", REM, 32'hFFFF_FF9C, 7, 32'hFFFF_FFFE, 33, 1);
        run_op("div_m100_m7", DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 14, 33, 1);
        run_op("div_min_2",  DIV, 32'h8000_0000, 2, 32'hC000_0000, 33, 1);
        run_op("divu_3_10",  DIVU, 3, 10, 0, 33, 1);
        run_op("remu_3_10",  REMU, 3, 10, 3, 33, 1);
        run_op("divu_max_1", DIVU, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 33, 1);

        run_op("div_5_0",    DIV, 5, 0, 32'hFFFF_FFFF, 1, 1);
        run_op("rem_5_0",    REM, 5, 0, 5, 1, 1);
        run_op("divu_5_0",   DIVU, 5, 0, 32'hFFFF_FFFF, 1, 1);
        run_op("remu_5_0",   REMU, 5, 0, 5, 1, 1);
        run_op("rem_m7_0",   REM, 32'hFFFF_FFF9, 0, 32'hFFFF_FFF9, 1, 1);

        run_op("div_ovf",    DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1);
        run_op("rem_ovf",    REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 1);
        run_op("divu_ovf",   DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 0, 33, 1);
        run_op("remu_ovf",   REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 1);

        // Backpressure: a pending request must not slip in during DONE or on the handshake edge
        run_op("bp", DIVU, 100, 7, 14, 33, 0);
        op = DIVU; a = 9; b = 3; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_ov", out_valid, 1);
            chk("bp_res", result, 14);
            chk("bp_inr", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk("bp_ov0", out_valid, 0);
        chk("bp_inr1", in_ready, 1);
        run_op("b2b_a", DIVU, 50, 5, 10, 33, 1);
        run_op("b2b_b", REMU, 50, 6, 2, 33, 1);

        // Flush at iteration 10
        op = DIVU; a = 1000; b = 3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("fl_busy_inr", in_ready, 0);
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("fl_ov", out_valid, 0);
        chk("fl_inr", in_ready, 1);
        op = DIVU; a = 9; b = 3; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_noacc", in_ready, 1);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("fl_noout", seen, 0);
        run_op("post_flush", DIVU, 9, 3, 3, 33, 1);

        // Reset at iteration 20
        op = DIVU; a = 1000; b = 3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mr_ov", out_valid, 0);
        chk("mr_res", result, 0);
        chk("mr_inr", in_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("mr_noout", seen, 0);
        run_op("post_rst", REMU, 1000, 3, 1, 33, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
